// File: rtl/aemb_imem_wb.sv
// aemb_imem_wb -- Wishbone instruction-memory responder.
//
// Serves classic-Wishbone read strobes from the instruction fetch unit out of
// a synchronous single-port program RAM. Each accepted read gets a one-cycle
// ack. A side load port writes program words at boot and never stalls the
// bus. Same-address, same-cycle read/write returns the old word (read-first).
//
// Build option: define AEMB_IMEM_PREFETCH_EN to add a one-word sequential
// prefetch. It lets a stream of consecutive fetches complete at one word per
// cycle. Without the macro the ack is purely registered and there is no
// prefetch state.
module aemb_imem_wb #(
    parameter int AW   = 10,
    parameter int WAIT = 0
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic [AW-1:0] iwb_adr_i,
    input  logic          iwb_stb_i,
    output logic          iwb_ack_o,
    output logic [31:0]   iwb_dat_o,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_adr_i,
    input  logic [31:0]   ld_dat_i
);

    localparam logic [2:0] WAIT_CNT = 3'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t        state_q;
    logic          ack_q;
    logic [2:0]    cnt_q;
    logic [31:0]   rdat_q;
    logic [31:0]   mem_q [2**AW];

    logic          hit;
    logic          miss;
    logic          rd_en;
    logic [AW-1:0] rd_adr;

`ifdef AEMB_IMEM_PREFETCH_EN
    localparam logic [AW-1:0] ADR_ONE = AW'(1);

    logic [AW-1:0] radr_q;
    logic [AW-1:0] pf_adr_q;
    logic          pf_vld_q;
    logic [2:0]    pf_cnt_q;

    logic          pf_match;
    logic          pf_stall;
    logic          pf_issue;
    logic [AW-1:0] pf_issue_adr;

    // Classify the current cycle: prefetch hit, stall on a pending prefetch,
    // miss, or prefetch issue; then pick the single RAM read address.
    always_comb begin
        pf_match     = (state_q == S_IDLE) && iwb_stb_i && pf_vld_q &&
                       (iwb_adr_i == pf_adr_q);
        hit          = pf_match && (pf_cnt_q == 3'd0);
        pf_stall     = pf_match && (pf_cnt_q != 3'd0);
        miss         = (state_q == S_IDLE) && iwb_stb_i && !pf_match;
        pf_issue     = hit || (state_q == S_ACK);
        pf_issue_adr = hit ? (iwb_adr_i + ADR_ONE) : (radr_q + ADR_ONE);
        rd_en        = miss || pf_issue;
        rd_adr       = miss ? iwb_adr_i : pf_issue_adr;
    end

    // Prefetch control: valid flag and its wait-state counter.
    always_ff @(posedge gclk) begin
        if (grst) begin
            pf_vld_q <= 1'b0;
            pf_cnt_q <= 3'd0;
        end else if (pf_issue) begin
            // A load to the word being prefetched in this very edge would be
            // missed by the read-first RAM, so the new prefetch starts invalid.
            pf_vld_q <= !(ld_we_i && (ld_adr_i == pf_issue_adr));
            pf_cnt_q <= WAIT_CNT;
        end else begin
            if (pf_cnt_q != 3'd0) begin
                pf_cnt_q <= pf_cnt_q - 3'd1;
            end
            if (miss || (ld_we_i && (ld_adr_i == pf_adr_q))) begin
                pf_vld_q <= 1'b0;
            end
        end
    end

    // Prefetch addresses: last accepted fetch address and prefetched address.
    always_ff @(posedge gclk) begin
        if (miss || hit) begin
            radr_q <= iwb_adr_i;
        end
        if (pf_issue) begin
            pf_adr_q <= pf_issue_adr;
        end
    end

    // A hit acks in the same cycle from the prefetched word in rdat_q.
    assign iwb_ack_o = ack_q | hit;
`else
    // Without prefetch every strobe seen in IDLE is a miss.
    always_comb begin
        hit    = 1'b0;
        miss   = (state_q == S_IDLE) && iwb_stb_i;
        rd_en  = miss;
        rd_adr = iwb_adr_i;
    end

    assign iwb_ack_o = ack_q;
`endif

    // Bus FSM: IDLE accepts a miss, WAIT burns wait states (abortable), ACK
    // presents the registered ack for one cycle.
    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    if (miss) begin
                        if (WAIT == 0) begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= WAIT_CNT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!iwb_stb_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 3'd0;
                    end else if (cnt_q <= 3'd1) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        cnt_q   <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    // Read data register: captures the RAM word on every issued read.
    always_ff @(posedge gclk) begin
        if (grst) begin
            rdat_q <= 32'd0;
        end else if (rd_en) begin
            rdat_q <= mem_q[rd_adr];
        end
    end

    // Program RAM write port (load port); contents survive reset.
    always_ff @(posedge gclk) begin
        if (ld_we_i) begin
            mem_q[ld_adr_i] <= ld_dat_i;
        end
    end

    assign iwb_dat_o = rdat_q;

endmodule

// File: tb/tb_aemb_imem_wb.sv
// Directed bench for aemb_imem_wb: three instances (AW=10/WAIT=0,
// AW=10/WAIT=3, AW=4/WAIT=0) sharing one load port.
module tb_aemb_imem_wb;

`ifdef AEMB_IMEM_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    logic        gclk;
    logic        grst;
    logic        ld_we;
    logic [9:0]  ld_adr;
    logic [31:0] ld_dat;

    logic        stb0, stb3, stb4;
    logic [9:0]  adr0, adr3;
    logic [3:0]  adr4;
    logic        ack0, ack3, ack4;
    logic [31:0] dat0, dat3, dat4;

    int n_assert;
    int n_fail;

    aemb_imem_wb #(.AW(10), .WAIT(0)) u0 (
        .gclk(gclk), .grst(grst), .iwb_adr_i(adr0), .iwb_stb_i(stb0),
        .iwb_ack_o(ack0), .iwb_dat_o(dat0), .ld_we_i(ld_we),
        .ld_adr_i(ld_adr), .ld_dat_i(ld_dat));

    aemb_imem_wb #(.AW(10), .WAIT(3)) u3 (
        .gclk(gclk), .grst(grst), .iwb_adr_i(adr3), .iwb_stb_i(stb3),
        .iwb_ack_o(ack3), .iwb_dat_o(dat3), .ld_we_i(ld_we),
        .ld_adr_i(ld_adr), .ld_dat_i(ld_dat));

    aemb_imem_wb #(.AW(4), .WAIT(0)) u4 (
        .gclk(gclk), .grst(grst), .iwb_adr_i(adr4), .iwb_stb_i(stb4),
        .iwb_ack_o(ack4), .iwb_dat_o(dat4), .ld_we_i(ld_we),
        .ld_adr_i(ld_adr[3:0]), .ld_dat_i(ld_dat));

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge gclk);
        #1;
    endtask

    task automatic set_bus(input int d, input logic s, input logic [9:0] a);
        case (d)
            0: begin stb0 = s; adr0 = a; end
            1: begin stb3 = s; adr3 = a; end
            default: begin stb4 = s; adr4 = a[3:0]; end
        endcase
    endtask

    function automatic logic ack_of(input int d);
        case (d)
            0: return ack0;
            1: return ack3;
            default: return ack4;
        endcase
    endfunction

    function automatic logic [31:0] dat_of(input int d);
        case (d)
            0: return dat0;
            1: return dat3;
            default: return dat4;
        endcase
    endfunction

    // Present a read, hold it until ack (bounded), check latency and data.
    // Returns just after the edge that ends the ack cycle, strobe still high.
    task automatic fetch(input int d, input logic [9:0] a, input int lat,
                         input logic [31:0] dat, input string tag);
        int  n;
        logic got;
        logic [31:0] d_at_ack;
        set_bus(d, 1'b1, a);
        n = 0;
        got = 1'b0;
        d_at_ack = 32'd0;
        while (!got && n <= 20) begin
            @(negedge gclk);
            if (ack_of(d)) begin
                got = 1'b1;
                d_at_ack = dat_of(d);
            end else begin
                nxt();
                n++;
            end
        end
        if (got) begin
            chk({tag, "_lat"}, 32'(n), 32'(lat));
            chk({tag, "_dat"}, d_at_ack, dat);
            nxt();
        end else begin
            chk({tag, "_timeout"}, 32'(n), 32'(lat));
        end
    endtask

    // Drop the strobe for one cycle and confirm no ack appears.
    task automatic rel(input int d, input string tag);
        set_bus(d, 1'b0, 10'd0);
        @(negedge gclk);
        chk(tag, {31'd0, ack_of(d)}, 32'd0);
        nxt();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        grst = 1'b1;
        ld_we = 1'b0; ld_adr = 10'd0; ld_dat = 32'd0;
        stb0 = 1'b0; stb3 = 1'b0; stb4 = 1'b0;
        adr0 = 10'd0; adr3 = 10'd0; adr4 = 4'd0;

        // Reset, then check the first post-reset cycle.
        repeat (3) nxt();
        grst = 1'b0;
        @(negedge gclk);
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_dat0", dat0, 32'd0);
        chk("rst_ack3", {31'd0, ack3}, 32'd0);
        chk("rst_dat3", dat3, 32'd0);
        chk("rst_ack4", {31'd0, ack4}, 32'd0);
        nxt();

        // Strobe low: no ack for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge gclk);
            chk("idle_ack0", {31'd0, ack0}, 32'd0);
            chk("idle_ack3", {31'd0, ack3}, 32'd0);
            nxt();
        end

        // Load program words 0..4 and word 15.
        for (int i = 0; i < 5; i++) begin
            ld_we = 1'b1;
            ld_adr = 10'(i);
            ld_dat = 32'h1111_1111 * 32'(i + 1);
            nxt();
        end
        ld_adr = 10'd15; ld_dat = 32'hF0F0_F0F0;
        nxt();
        ld_we = 1'b0;
        nxt();

        // WAIT=0 single read of address 2.
        fetch(0, 10'd2, 1, 32'h3333_3333, "w0_a2");
        rel(0, "w0_ack_low");

        // WAIT=3 read of address 1.
        fetch(1, 10'd1, 4, 32'h2222_2222, "w3_a1");
        rel(1, "w3_ack_low");

        // WAIT=3 read aborted in cycle 2, then a fresh read from cycle 3.
        set_bus(1, 1'b1, 10'd1);
        @(negedge gclk);
        chk("abort_c0", {31'd0, ack3}, 32'd0);
        nxt();
        @(negedge gclk);
        chk("abort_c1", {31'd0, ack3}, 32'd0);
        nxt();
        set_bus(1, 1'b0, 10'd0);
        @(negedge gclk);
        chk("abort_c2", {31'd0, ack3}, 32'd0);
        nxt();
        fetch(1, 10'd3, 4, 32'h4444_4444, "after_abort_a3");
        // Next sequential word: with prefetch it waits out the counter.
        fetch(1, 10'd4, (PF != 0) ? 3 : 4, 32'h5555_5555, "w3_seq_a4");
        rel(1, "w3_ack_low2");

        // Sequential stream 0..3, then a jump back to 0.
        fetch(0, 10'd0, 1, 32'h1111_1111, "seq_a0");
        fetch(0, 10'd1, (PF != 0) ? 0 : 1, 32'h2222_2222, "seq_a1");
        fetch(0, 10'd2, (PF != 0) ? 0 : 1, 32'h3333_3333, "seq_a2");
        fetch(0, 10'd3, (PF != 0) ? 0 : 1, 32'h4444_4444, "seq_a3");
        fetch(0, 10'd0, 1, 32'h1111_1111, "jump_a0");
        rel(0, "seq_ack_low");

        // AW=4 wrap: 15 then 0.
        fetch(2, 10'd15, 1, 32'hF0F0_F0F0, "wrap_a15");
        fetch(2, 10'd0, (PF != 0) ? 0 : 1, 32'h1111_1111, "wrap_a0");
        rel(2, "wrap_ack_low");

        // Load-write to the prefetched word invalidates it.
        fetch(0, 10'd1, (PF != 0) ? 0 : 1, 32'h2222_2222, "inv_a1");
        set_bus(0, 1'b0, 10'd0);
        ld_we = 1'b1; ld_adr = 10'd2; ld_dat = 32'hDEAD_BEEF;
        @(negedge gclk);
        chk("inv_ack_low", {31'd0, ack0}, 32'd0);
        nxt();
        ld_we = 1'b0;
        fetch(0, 10'd2, 1, 32'hDEAD_BEEF, "inv_a2");
        rel(0, "inv_ack_low2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
